// File: rtl/sigcomp_pkg.sv
// Shared types and constants for the y-vector signature compactor.
// Holds the FSM state encoding, MISR defaults and slice-count helper.
`timescale 1ns/1ps
package sigcomp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEF_SEED = 32'hFFFF_FFFF;

    // Number of SIG_WIDTH slices needed to cover a y vector.
    function automatic int nchunk(input int yw, input int sw);
        return (yw + sw - 1) / sw;
    endfunction

endpackage

// File: rtl/y_fold_xor.sv
// Combinational fold of a wide vector into one signature-width word.
// The vector is zero-padded to whole slices, then all slices are XORed.
`timescale 1ns/1ps
module y_fold_xor
    import sigcomp_pkg::*;
#(
    parameter int unsigned Y_WIDTH   = 421,
    parameter int unsigned SIG_WIDTH = 32
) (
    input  logic [Y_WIDTH-1:0]   y_i,
    output logic [SIG_WIDTH-1:0] fold_o
);

    localparam int NCH  = nchunk(Y_WIDTH, SIG_WIDTH);
    localparam int NPAD = NCH * SIG_WIDTH;

    logic [NPAD-1:0] ypad;

    assign ypad = NPAD'(y_i);

    // XOR-reduce every slice; the top slice carries the zero padding.
    always_comb begin
        fold_o = '0;
        for (int i = 0; i < NCH; i++) begin
            fold_o = fold_o ^ ypad[i*SIG_WIDTH +: SIG_WIDTH];
        end
    end

endmodule

// File: rtl/y_signature_compactor.sv
// Compresses a stream of y samples into a MISR signature and, after a
// fixed sample count, compares it against a golden value.
`timescale 1ns/1ps
module y_signature_compactor
    import sigcomp_pkg::*;
#(
    parameter int unsigned          Y_WIDTH   = 421,
    parameter int unsigned          SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = DEF_POLY,
    parameter logic [SIG_WIDTH-1:0] SEED      = DEF_SEED,
    parameter int unsigned          SAMPLES   = 21,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 y_valid,
    input  logic [Y_WIDTH-1:0]   y,
    input  logic [SIG_WIDTH-1:0] expected_sig,
    output logic                 busy,
    output logic                 done,
    output logic                 match,
    output logic [SIG_WIDTH-1:0] signature,
    output logic [CNT_W-1:0]     sample_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    if ((SAMPLES < 1) ||
        (longint'(SAMPLES) >= (64'd1 << CNT_W))) begin : g_bad_samples
        $error("SAMPLES must be in 1 .. 2**CNT_W-1");
    end

    state_e               state_q, state_d;
    logic [SIG_WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 match_q, match_d;

    logic [SIG_WIDTH-1:0] fold;
    logic [SIG_WIDTH-1:0] sig_next;
    logic [CNT_W-1:0]     cnt_inc;

    y_fold_xor #(
        .Y_WIDTH  (Y_WIDTH),
        .SIG_WIDTH(SIG_WIDTH)
    ) u_fold (
        .y_i   (y),
        .fold_o(fold)
    );

    // One MISR shift with polynomial feedback and the folded sample.
    always_comb begin
        sig_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
                 ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
                 ^ fold;
    end

    // Saturating increment of the accepted-sample counter.
    always_comb begin
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state logic; start overrides every state, including a
    // coincident y_valid, so that sample is dropped.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        match_d = match_q;
        if (start) begin
            state_d = ST_RUN;
            sig_d   = SEED;
            cnt_d   = '0;
            done_d  = 1'b0;
            match_d = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (y_valid) begin
                        sig_d = sig_next;
                        cnt_d = cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    match_d = (sig_q == expected_sig);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and datapath registers; reset drops any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    assign busy         = (state_q == ST_RUN) || (state_q == ST_CHECK);
    assign done         = done_q;
    assign match        = match_q;
    assign signature    = sig_q;
    assign sample_count = cnt_q;

endmodule

// File: doc/y_signature_compactor.md
Name: y_signature_compactor

Overview:
- Consumes the wide `y` output vector of a fuzzed `top` design once per sampled clock and compresses the stream into a 32-bit MISR signature.
- After a programmed number of samples, compares the signature against an expected value and reports pass/fail.
- Sits directly downstream of the design under test in the simulation harness. Replaces per-cycle `%b` strobing with a single comparable signature per run.

Parameters:
- Y_WIDTH, 421, width of the observed output vector `y`.
- SIG_WIDTH, 32, signature width.
- POLY, 32'h04C11DB7, MISR feedback polynomial (CRC-32 taps).
- SEED, 32'hFFFFFFFF, signature value loaded on reset and on `start`.
- SAMPLES, 21, number of `y` samples folded per run (≥1).
- CNT_W, 16, width of the sample counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; reseeds and begins a run.
- y_valid  input  1  `y` is sampled this cycle.
- y  input  Y_WIDTH  output vector of the design under test.
- expected_sig  input  SIG_WIDTH  golden signature; sampled in CHECK.
- busy  output  1  high in RUN and CHECK.
- done  output  1  run finished; held until next `start`.
- match  output  1  signature equalled `expected_sig`; valid when `done`=1.
- signature  output  SIG_WIDTH  current MISR value.
- sample_count  output  CNT_W  samples accepted in the current run.

Behaviour:
- Reset (async, `rst_n`=0) forces:
  - state=IDLE
  - signature=SEED
  - sample_count=0
  - busy=0, done=0, match=0
- Release of reset is synchronous to `clk`.
- Fold (combinational):
  - `y` is zero-padded to NCHUNK=ceil(Y_WIDTH/SIG_WIDTH) slices of SIG_WIDTH bits. For 421 bits this is 14 slices; slice 13 holds `y[420:416]` in bits [4:0].
  - `fold` = XOR of all slices.
- MISR step: `sig_next = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold`.
- FSM states: IDLE, RUN, CHECK, DONE.
  - IDLE: outputs hold. On `start`, signature←SEED, sample_count←0, go to RUN.
  - RUN: each cycle with `y_valid`=1, signature←sig_next and sample_count++.
    - If the accepted sample is number SAMPLES, go to CHECK in the same edge.
    - `y_valid`=0 leaves the state unchanged.
  - CHECK: one cycle. match←(signature==expected_sig), done←1, go to DONE. `y_valid` is ignored.
  - DONE: done/match/signature hold. `start` clears done and match, reseeds, and goes to RUN.
- Latency: if the last sample is accepted at edge k, then `done`=1 and `match` are visible after edge k+1.
- `start` while in RUN or CHECK: abort and restart. Reseed, count=0, stay or enter RUN; done=0.
- `start` and `y_valid` in the same cycle: `start` wins and that sample is not folded.
- sample_count saturates at 2^CNT_W−1. SAMPLES must be < 2^CNT_W (elaboration-time check).
- Reset mid-run discards all progress; no partial result is reported.
- Width rules:
  - All arithmetic is unsigned bitwise XOR/shift; no carries.
  - `expected_sig` is compared at full SIG_WIDTH.
  - SIG_WIDTH ≠ 32 requires a matching POLY.

Decomposition:
- Shared package `sigcomp_pkg`:
  - state enum (IDLE/RUN/CHECK/DONE)
  - default POLY and SEED constants
  - function `nchunk(Y_WIDTH, SIG_WIDTH)`
- One sub-module, `y_fold_xor`: purely combinational, parameterised Y_WIDTH/SIG_WIDTH, produces `fold`. The FSM and MISR stay in the top block.

Test Plan:
- Reset values: assert `rst_n`=0 mid-cycle → immediately signature=FFFFFFFF, sample_count=0, busy=0, done=0, match=0.
- Zero vector: SAMPLES=1, `start`, then `y`=0 with `y_valid` for one cycle → signature=FB3EE249. With expected_sig=FB3EE249, `done`=1 and `match`=1 two edges after the sample.
- Single bit: SAMPLES=1, `y`=1 → signature=FB3EE248. With expected_sig=FB3EE249, `match`=0 and `done`=1.
- All-ones vector and padding: SAMPLES=1, `y`=all ones (421 bits) → fold=FFFFFFE0, signature=04C11DA9.
- Gaps and restart:
  - SAMPLES=21 with `y_valid` toggling every other cycle → done only after the 21st valid sample, with sample_count=21.
  - A second run with `start` asserted at sample 10 → count restarts at 0 and signature restarts at SEED; the final result equals that of an uninterrupted run.
- Collision and reset: `start` and `y_valid` in the same cycle → sample_count stays 0. `rst_n` low during CHECK → done never asserts and state returns to IDLE.
